// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register index width, the hardwired
// zero register index and the common word/index types.
package mips_pkg;

  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [31:0]       word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/mips_reg_file.sv
// mips_reg_file: 32-entry MIPS general-purpose register file.
// One synchronous write per cycle, two combinational read ports, $0 hardwired
// to zero, asynchronous active-high reset clearing every register.
// Optional build macro REGFILE_BYPASS_EN: when defined, a write to the index
// being read in the same cycle is forwarded combinationally to that read port.
module mips_reg_file #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [N-1:0]      WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [N-1:0]      ReadData1,
  output logic [N-1:0]      ReadData2
);
  import mips_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  // Effective write strobe: index 0 is never written, so it also never
  // qualifies for the bypass path.
  logic         w_we;
  logic [N-1:0] w_regs [DEPTH];

  assign w_we = RegWrite && (WriteReg != ADDR_W'(ZERO_REG));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_store
        logic [N-1:0] r_q;
        // Register gi: cleared by reset, loaded when it is the write target.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_q <= '0;
          end else if (w_we && (WriteReg == ADDR_W'(gi))) begin
            r_q <= WriteData;
          end
        end
        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  // Two independent read decoders, with optional same-cycle write-through.
  always_comb begin
    ReadData1 = w_regs[ReadReg1];
    ReadData2 = w_regs[ReadReg2];
`ifdef REGFILE_BYPASS_EN
    if (!rst && w_we && (ReadReg1 == WriteReg)) begin
      ReadData1 = WriteData;
    end
    if (!rst && w_we && (ReadReg2 == WriteReg)) begin
      ReadData2 = WriteData;
    end
`endif
  end

endmodule
